// File: rtl/ts_multi_ctrl_if.sv
// rtl/ts_multi_ctrl_if.sv - handshake bundle between the TS sequencer and the analog TS macro
interface ts_multi_ctrl_if #(
  parameter int NCH = 4,
  parameter int DW  = 8
);
  localparam int CW = $clog2(NCH);

  logic          D2A_TS_EN;
  logic          D2A_TS_START_EN;
  logic [CW-1:0] D2A_TS_CH_SEL;
  logic          A2D_TS_DETOK;
  logic [DW-1:0] A2D_TS_DOUT;

  modport master (
    output D2A_TS_EN,
    output D2A_TS_START_EN,
    output D2A_TS_CH_SEL,
    input  A2D_TS_DETOK,
    input  A2D_TS_DOUT
  );

  modport slave (
    input  D2A_TS_EN,
    input  D2A_TS_START_EN,
    input  D2A_TS_CH_SEL,
    output A2D_TS_DETOK,
    output A2D_TS_DOUT
  );
endinterface

// File: rtl/ts_multi_ctrl.sv
// rtl/ts_multi_ctrl.sv - multi-channel TS sequencer with averaging, trim and timeout; TS_ALARM_EN adds alarm flags
module ts_multi_ctrl #(
  parameter int NCH         = 4,
  parameter int DW          = 8,
  parameter int AVG_LOG2    = 2,
  parameter int SETTLE_CYC  = 16,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              clk,
  input  logic              RST,
  input  logic              FLOCK,
  input  logic              reg_ts_en,
  input  logic [NCH-1:0]    reg_ch_mask,
  input  logic [3:0]        reg_offset,
  input  logic [DW-1:0]     reg_alarm_hi,
  input  logic [DW-1:0]     reg_alarm_hyst,
  ts_multi_ctrl_if.master   ts,
  output logic [NCH*DW-1:0] ts_out,
  output logic [NCH-1:0]    ts_valid,
  output logic [NCH-1:0]    ts_upd,
  output logic [NCH-1:0]    ts_timeout,
  output logic [NCH-1:0]    ts_alarm
);

  localparam int CW   = $clog2(NCH);
  localparam int AW   = DW + AVG_LOG2;
  localparam int NS   = 1 << AVG_LOG2;
  localparam int SW   = AVG_LOG2 + 1;
  localparam int TMAX = (SETTLE_CYC > TIMEOUT_CYC) ? SETTLE_CYC : TIMEOUT_CYC;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE_CYC - 1);
  localparam logic [TW-1:0] TMO_LAST    = TW'(TIMEOUT_CYC - 1);
  localparam logic [SW-1:0] NS_W        = SW'(NS);
  localparam logic [CW-1:0] CH_LAST     = CW'(NCH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PWRUP,
    S_SELECT,
    S_CONV,
    S_GAP,
    S_WRITE
  } state_t;

  state_t state_q, state_d;

  logic [1:0]        sync_q;
  logic              detok_s;
  logic [TW-1:0]     cyc_q;
  logic [CW-1:0]     ch_q;
  logic [AW-1:0]     acc_q;
  logic [SW-1:0]     smp_q;
  logic              armed_q;
  logic              start_q;

  logic [NCH*DW-1:0] ts_out_q;
  logic [NCH-1:0]    ts_valid_q;
  logic [NCH-1:0]    ts_upd_q;
  logic [NCH-1:0]    ts_timeout_q;

  logic              run_ok;
  logic              first_sel;
  logic              capture;
  logic              tmo_hit;
  logic              do_write;
  logic              nxt_found;
  logic [CW-1:0]     nxt_ch;
  logic [CW-1:0]     scan_idx;
  logic [DW-1:0]     avg;
  logic signed [DW+1:0] trim_sum;
  logic [DW-1:0]     res;

  assign run_ok    = reg_ts_en && FLOCK;
  assign detok_s   = sync_q[1];
  assign first_sel = (state_q == S_SELECT) && (cyc_q == '0);
  assign capture   = (state_q == S_CONV) && armed_q && detok_s;
  assign tmo_hit   = (state_q == S_CONV) && !capture && (cyc_q == TMO_LAST);
  assign do_write  = (state_q == S_WRITE) && run_ok;

  // Two-flop synchronizer for the asynchronous conversion-done strobe
  always_ff @(posedge clk) begin
    if (RST) sync_q <= '0;
    else     sync_q <= {sync_q[0], ts.A2D_TS_DETOK};
  end

  // Round-robin search: first enabled channel strictly after the last one, wrapping
  always_comb begin
    nxt_found = 1'b0;
    nxt_ch    = '0;
    scan_idx  = '0;
    for (int i = 1; i <= NCH; i++) begin
      scan_idx = CW'((int'(ch_q) + i) % NCH);
      if (!nxt_found && reg_ch_mask[scan_idx]) begin
        nxt_found = 1'b1;
        nxt_ch    = scan_idx;
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (RST) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; losing enable or PLL lock aborts from any state
  always_comb begin
    state_d = state_q;
    if (!run_ok) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:   if (|reg_ch_mask) state_d = S_PWRUP;
        S_PWRUP:  if (cyc_q == SETTLE_LAST) state_d = S_SELECT;
        S_SELECT: begin
          if (first_sel && !nxt_found)     state_d = S_IDLE;
          else if (cyc_q == SETTLE_LAST)   state_d = S_CONV;
        end
        S_CONV: begin
          if (capture)      state_d = S_GAP;
          else if (tmo_hit) state_d = S_SELECT;
        end
        S_GAP:    state_d = (smp_q < NS_W) ? S_CONV : S_WRITE;
        S_WRITE:  state_d = S_SELECT;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  // Analog-side outputs decoded from the current state
  always_comb begin
    ts.D2A_TS_EN       = (state_q != S_IDLE);
    ts.D2A_TS_START_EN = start_q;
    ts.D2A_TS_CH_SEL   = (state_q != S_IDLE) ? ch_q : '0;
  end

  // Sequencing datapath: cycle counter, channel pointer, accumulator, arm flag, start request
  always_ff @(posedge clk) begin
    if (RST) begin
      cyc_q   <= '0;
      ch_q    <= CH_LAST;
      acc_q   <= '0;
      smp_q   <= '0;
      armed_q <= 1'b0;
      start_q <= 1'b0;
    end else begin
      cyc_q   <= ((state_d != state_q) || (state_q == S_IDLE)) ? '0 : cyc_q + TW'(1);
      start_q <= (state_q == S_CONV) && (state_d == S_CONV);

      if (state_q == S_IDLE)             ch_q <= CH_LAST;
      else if (first_sel && nxt_found)   ch_q <= nxt_ch;

      if ((state_q == S_SELECT) || (state_d == S_IDLE)) begin
        acc_q <= '0;
        smp_q <= '0;
      end else if (capture) begin
        acc_q <= acc_q + AW'(ts.A2D_TS_DOUT);
        smp_q <= smp_q + SW'(1);
      end

      if ((state_d == S_CONV) && (state_q != S_CONV)) armed_q <= 1'b0;
      else if ((state_q == S_CONV) && !detok_s)       armed_q <= 1'b1;
    end
  end

  // Average, add signed trim, clamp to the unsigned DW range
  always_comb begin
    avg      = acc_q[AW-1:AVG_LOG2];
    trim_sum = $signed({2'b00, avg}) + $signed({{(DW-2){reg_offset[3]}}, reg_offset});
    res      = trim_sum[DW-1:0];
    if (trim_sum[DW+1])  res = '0;
    else if (trim_sum[DW]) res = '1;
  end

  // Per-channel result registers and status flags
  always_ff @(posedge clk) begin
    if (RST) begin
      ts_out_q     <= '0;
      ts_valid_q   <= '0;
      ts_upd_q     <= '0;
      ts_timeout_q <= '0;
    end else begin
      ts_upd_q <= '0;
      for (int c = 0; c < NCH; c++) begin
        if (ch_q == CW'(c)) begin
          if (do_write) begin
            ts_out_q[c*DW +: DW] <= res;
            ts_valid_q[c]        <= 1'b1;
            ts_upd_q[c]          <= 1'b1;
            ts_timeout_q[c]      <= 1'b0;
          end else if (tmo_hit && run_ok) begin
            ts_timeout_q[c]      <= 1'b1;
          end
        end
      end
    end
  end

  assign ts_out     = ts_out_q;
  assign ts_valid   = ts_valid_q;
  assign ts_upd     = ts_upd_q;
  assign ts_timeout = ts_timeout_q;

`ifdef TS_ALARM_EN
  logic [NCH-1:0] alarm_q;
  logic [DW-1:0]  alarm_lo;

  assign alarm_lo = (reg_alarm_hi > reg_alarm_hyst) ? (reg_alarm_hi - reg_alarm_hyst) : '0;

  // Hysteretic over-temperature flag, re-evaluated on every result write
  always_ff @(posedge clk) begin
    if (RST) begin
      alarm_q <= '0;
    end else if (do_write) begin
      for (int c = 0; c < NCH; c++) begin
        if (ch_q == CW'(c)) begin
          if (res >= reg_alarm_hi)  alarm_q[c] <= 1'b1;
          else if (res < alarm_lo)  alarm_q[c] <= 1'b0;
        end
      end
    end
  end

  assign ts_alarm = alarm_q;
`else
  logic unused_alarm_regs;
  assign unused_alarm_regs = ^{reg_alarm_hi, reg_alarm_hyst};
  assign ts_alarm = '0;
`endif

endmodule

// File: tb/tb_ts_multi_ctrl.sv
// tb/tb_ts_multi_ctrl.sv - directed self-checking bench for ts_multi_ctrl
module tb_ts_multi_ctrl;
  localparam int NCH = 4;
  localparam int DW  = 8;

  logic            clk = 1'b0;
  logic            RST;
  logic            FLOCK;
  logic            reg_ts_en;
  logic [NCH-1:0]  reg_ch_mask;
  logic [3:0]      reg_offset;
  logic [DW-1:0]   reg_alarm_hi;
  logic [DW-1:0]   reg_alarm_hyst;
  logic [NCH*DW-1:0] ts_out;
  logic [NCH-1:0]  ts_valid;
  logic [NCH-1:0]  ts_upd;
  logic [NCH-1:0]  ts_timeout;
  logic [NCH-1:0]  ts_alarm;

  ts_multi_ctrl_if #(.NCH(NCH), .DW(DW)) bus ();

  ts_multi_ctrl #(
    .NCH(NCH), .DW(DW), .AVG_LOG2(2), .SETTLE_CYC(16), .TIMEOUT_CYC(1024)
  ) dut (
    .clk(clk), .RST(RST), .FLOCK(FLOCK), .reg_ts_en(reg_ts_en),
    .reg_ch_mask(reg_ch_mask), .reg_offset(reg_offset),
    .reg_alarm_hi(reg_alarm_hi), .reg_alarm_hyst(reg_alarm_hyst),
    .ts(bus),
    .ts_out(ts_out), .ts_valid(ts_valid), .ts_upd(ts_upd),
    .ts_timeout(ts_timeout), .ts_alarm(ts_alarm)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  int            adc_lat = 425;
  bit            hang    = 1'b0;
  logic [DW-1:0] seq [4];
  bit            sel_mon = 1'b0;
  bit            bad_sel = 1'b0;

  bit            adc_init   = 1'b0;
  bit            start_prev = 1'b0;
  bit            pend       = 1'b0;
  int            cnt        = 0;
  int            k          = 0;

  logic [NCH-1:0] u;
  int             n;

  // ADC model: drop DETOK on START_EN rise, raise it adc_lat cycles later with the next sample
  always @(negedge clk) begin
    if (!adc_init) begin
      bus.A2D_TS_DETOK = 1'b1;
      bus.A2D_TS_DOUT  = '0;
      adc_init = 1'b1;
    end
    if (bus.D2A_TS_START_EN && !start_prev) begin
      bus.A2D_TS_DETOK = 1'b0;
      pend = 1'b1;
      cnt  = adc_lat;
    end else if (pend && !hang) begin
      if (cnt <= 1) begin
        bus.A2D_TS_DOUT  = seq[k];
        bus.A2D_TS_DETOK = 1'b1;
        k    = (k + 1) % 4;
        pend = 1'b0;
      end else begin
        cnt = cnt - 1;
      end
    end
    start_prev = bus.D2A_TS_START_EN;
  end

  // Channel-select monitor for the sparse-mask scan
  always @(negedge clk) begin
    if (sel_mon && bus.D2A_TS_EN && (bus.D2A_TS_CH_SEL == 2'd0 || bus.D2A_TS_CH_SEL == 2'd2))
      bad_sel = 1'b1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_seq(input logic [DW-1:0] v);
    for (int i = 0; i < 4; i++) seq[i] = v;
  endtask

  task automatic wait_upd(input int budget, output logic [NCH-1:0] got);
    int c;
    c = 0;
    @(negedge clk);
    while (ts_upd == '0 && c < budget) begin
      @(negedge clk);
      c++;
    end
    got = ts_upd;
    check("upd_seen", 64'(ts_upd != '0), 64'd1);
  endtask

  task automatic wait_start(input int budget);
    int c;
    c = 0;
    while (!bus.D2A_TS_START_EN && c < budget) begin
      @(negedge clk);
      c++;
    end
    check("start_seen", 64'(bus.D2A_TS_START_EN), 64'd1);
  endtask

  task automatic restart(input string tag, input logic [NCH-1:0] m, input logic [3:0] off);
    reg_ts_en = 1'b0;
    @(negedge clk);
    check({tag, "_abort_en"}, 64'(bus.D2A_TS_EN), 64'd0);
    check({tag, "_abort_start"}, 64'(bus.D2A_TS_START_EN), 64'd0);
    reg_ch_mask = m;
    reg_offset  = off;
    @(negedge clk);
    reg_ts_en = 1'b1;
  endtask

  initial begin
    RST = 1'b1; FLOCK = 1'b0; reg_ts_en = 1'b0; reg_ch_mask = '0; reg_offset = '0;
    reg_alarm_hi = 8'd100; reg_alarm_hyst = 8'd5;
    seq[0] = 8'd10; seq[1] = 8'd12; seq[2] = 8'd14; seq[3] = 8'd16;
    repeat (3) @(negedge clk);

    check("rst_en",      64'(bus.D2A_TS_EN),       64'd0);
    check("rst_start",   64'(bus.D2A_TS_START_EN), 64'd0);
    check("rst_chsel",   64'(bus.D2A_TS_CH_SEL),   64'd0);
    check("rst_out",     64'(ts_out),              64'd0);
    check("rst_valid",   64'(ts_valid),            64'd0);
    check("rst_upd",     64'(ts_upd),              64'd0);
    check("rst_timeout", 64'(ts_timeout),          64'd0);
    check("rst_alarm",   64'(ts_alarm),            64'd0);

    RST = 1'b0;
    @(negedge clk);
    check("idle_no_lock_en", 64'(bus.D2A_TS_EN), 64'd0);
    FLOCK = 1'b1; reg_ts_en = 1'b1; reg_ch_mask = 4'b1111;

    // Full scan: 10,12,14,16 average to 13 on every channel, order 0,1,2,3,0
    for (int i = 0; i < 5; i++) begin
      wait_upd(3000, u);
      check($sformatf("p1_upd%0d", i), 64'(u), 64'(4'b0001 << (i % 4)));
    end
    for (int c = 0; c < NCH; c++)
      check($sformatf("p1_out%0d", c), 64'(ts_out[c*DW +: DW]), 64'd13);
    check("p1_valid", 64'(ts_valid), 64'hF);

    adc_lat = 20;

    // Offset -8 on samples of 5 clamps to 0
    set_seq(8'd5);
    restart("p2a", 4'b1111, 4'b1000);
    wait_upd(600, u);
    check("p2a_upd", 64'(u), 64'b0001);
    check("p2a_out0", 64'(ts_out[7:0]), 64'd0);

    // Offset +7 on samples of 250 clamps to 255
    set_seq(8'd250);
    restart("p2b", 4'b1111, 4'b0111);
    wait_upd(600, u);
    check("p2b_out0", 64'(ts_out[7:0]), 64'd255);
    check("p2b_out1_kept", 64'(ts_out[15:8]), 64'd13);

    // Offset -3 on mean 13 gives 10
    seq[0] = 8'd10; seq[1] = 8'd12; seq[2] = 8'd14; seq[3] = 8'd16;
    restart("p2c", 4'b1111, 4'b1101);
    wait_upd(600, u);
    check("p2c_out0", 64'(ts_out[7:0]), 64'd10);

    // Sparse mask 1010 alternates between channels 1 and 3
    set_seq(8'd20);
    restart("p3", 4'b1010, 4'b0000);
    sel_mon = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_upd(600, u);
      check($sformatf("p3_upd%0d", i), 64'(u), (i % 2 == 0) ? 64'b0010 : 64'b1000);
    end
    sel_mon = 1'b0;
    check("p3_no_sel_0_2", 64'(bad_sel), 64'd0);
    check("p3_out1", 64'(ts_out[15:8]), 64'd20);
    check("p3_out3", 64'(ts_out[31:24]), 64'd20);

    // Channel 2 never completes: timeout after 1024 CONV cycles, result retained
    hang = 1'b1;
    restart("p4", 4'b0100, 4'b0000);
    wait_start(200);
    n = 0;
    while (!ts_timeout[2] && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("p4_tmo_cycles", 64'(n), 64'd1023);
    check("p4_timeout", 64'(ts_timeout), 64'b0100);
    check("p4_out2_kept", 64'(ts_out[23:16]), 64'd13);
    check("p4_no_upd", 64'(ts_upd), 64'd0);
    set_seq(8'd40);
    hang = 1'b0;
    wait_upd(600, u);
    check("p4_upd", 64'(u), 64'b0100);
    check("p4_out2", 64'(ts_out[23:16]), 64'd40);
    check("p4_timeout_clr", 64'(ts_timeout), 64'd0);

    // PLL lock lost mid-conversion, then recovered
    set_seq(8'd30);
    restart("p5", 4'b1111, 4'b0000);
    wait_start(200);
    repeat (3) @(negedge clk);
    FLOCK = 1'b0;
    @(negedge clk);
    check("p5_en",    64'(bus.D2A_TS_EN),       64'd0);
    check("p5_start", 64'(bus.D2A_TS_START_EN), 64'd0);
    check("p5_chsel", 64'(bus.D2A_TS_CH_SEL),   64'd0);
    check("p5_out_kept", 64'(ts_out), 64'h14_28_14_0A);
    check("p5_valid", 64'(ts_valid), 64'hF);
    @(negedge clk);
    FLOCK = 1'b1;
    wait_upd(600, u);
    check("p5_restart_ch0", 64'(u), 64'b0001);
    check("p5_out0", 64'(ts_out[7:0]), 64'd30);

`ifdef TS_ALARM_EN
    begin
      logic [DW-1:0] vals [5];
      logic          exp_al [5];
      vals[0] = 8'd99;  vals[1] = 8'd100; vals[2] = 8'd97; vals[3] = 8'd95; vals[4] = 8'd94;
      exp_al[0] = 1'b0; exp_al[1] = 1'b1; exp_al[2] = 1'b1; exp_al[3] = 1'b1; exp_al[4] = 1'b0;
      set_seq(vals[0]);
      restart("p6", 4'b0001, 4'b0000);
      for (int i = 0; i < 5; i++) begin
        if (i > 0) set_seq(vals[i]);
        wait_upd(600, u);
        check($sformatf("p6_out%0d", i), 64'(ts_out[7:0]), 64'(vals[i]));
        check($sformatf("p6_alarm%0d", i), 64'(ts_alarm[0]), 64'(exp_al[i]));
      end
    end
`else
    check("alarm_tied_low", 64'(ts_alarm), 64'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ts_multi_ctrl.md
# ts_multi_ctrl

Multi-channel temperature-sensor sequencer. It replaces the single-channel TS controller in the analog-interface layer. It powers the TS analog macro once FLOCK is asserted, then scans up to NCH sensor channels round-robin, averaging 2^AVG_LOG2 conversions per channel. It applies a signed trim offset with saturation and publishes per-channel results with valid, timeout and (optional) alarm flags.

## Interface
- NCH, 4: number of channels; allowed range 2..16.
- DW, 8: ADC data width.
- AVG_LOG2, 2: log2 of the number of samples averaged per channel; allowed range 0..4.
- SETTLE_CYC, 16: cycles to wait after power-up and after each channel select.
- TIMEOUT_CYC, 1024: maximum number of cycles allowed for one conversion.
---
- clk  in  1  system clock, 16 MHz.
- RST  in  1  synchronous, active-high reset.
- FLOCK  in  1  PLL lock; sequencing runs only while this is 1.
- reg_ts_en  in  1  block enable.
- reg_ch_mask  in  NCH  channel scan mask; bit i enables channel i.
- reg_offset  in  4  signed two's-complement trim, range -8..+7 LSB.
- reg_alarm_hi  in  DW  alarm threshold (TS_ALARM_EN builds only).
- reg_alarm_hyst  in  DW  alarm hysteresis (TS_ALARM_EN builds only).
- A2D_TS_DETOK  in  1  conversion done, asynchronous.
- A2D_TS_DOUT  in  DW  ADC result; stable while DETOK is high.
- D2A_TS_EN  out  1  analog power enable.
- D2A_TS_START_EN  out  1  conversion request.
- D2A_TS_CH_SEL  out  $clog2(NCH)  selected channel.
- ts_out  out  NCH*DW  packed per-channel results; channel i occupies bits [i*DW +: DW].
- ts_valid  out  NCH  sticky flag: channel has at least one result.
- ts_upd  out  NCH  1-cycle pulse when a channel's result is written.
- ts_timeout  out  NCH  sticky per-channel conversion timeout.
- ts_alarm  out  NCH  over-temperature flag (TS_ALARM_EN builds only).

## Operation
- DETOK passes through a 2-flop synchronizer to give detok_s. DOUT is captured unsynchronized on the first cycle that detok_s is seen high.
- FSM states:
  - IDLE: D2A_TS_EN=0. Move to PWRUP when reg_ts_en && FLOCK && |reg_ch_mask.
  - PWRUP: D2A_TS_EN=1 for SETTLE_CYC cycles, then go to SELECT.
  - SELECT: pick the next set mask bit strictly after the last channel, wrapping from NCH-1 to 0. The first scan after IDLE starts at channel 0. Drive CH_SEL, clear the accumulator and sample count, then hold SETTLE_CYC cycles and go to CONV.
  - CONV: START_EN=1. Wait for detok_s==0 (arm), then detok_s==1. On that edge: capture DOUT, acc += DOUT, START_EN=0, go to GAP.
  - GAP: START_EN=0 for exactly 1 cycle. If the sample count is below 2^AVG_LOG2 go back to CONV; otherwise go to WRITE.
  - WRITE: avg = acc >> AVG_LOG2 (acc width DW+AVG_LOG2, truncating). res = avg + sext(reg_offset), saturated to 0..2^DW-1. Write res to ts_out[ch], set ts_valid[ch], pulse ts_upd[ch], clear ts_timeout[ch], then go to SELECT.
- Timeout: the cycle counter starts on CONV entry. When it reaches TIMEOUT_CYC: set ts_timeout[ch], discard the accumulator, leave ts_out[ch] unchanged, go to SELECT.
- Abort: if reg_ts_en or FLOCK drops in any state, go to IDLE on the next edge. Outputs EN, START_EN and CH_SEL go to 0 and the partial accumulator is discarded. ts_out, ts_valid and ts_timeout are retained.
- A mask change takes effect at the next SELECT. If the mask is 0 at SELECT, go to IDLE.
- Reset: all outputs are 0, ts_out=0, FSM in IDLE, last channel = NCH-1.

## Timing
- Latency from capture to write: GAP (1 cycle) + WRITE (1 cycle). ts_out updates and ts_upd pulses on the same edge.
- START_EN rises 1 cycle after CONV entry is registered. It is low for at least 1 cycle between conversions.
- DETOK-to-capture latency is 2–3 cycles (synchronizer).
- Conversion time per channel ≈ 2^AVG_LOG2 × (ADC time + 4) + SETTLE_CYC + 2 cycles.
- A DETOK already high at CONV entry is ignored until it has been seen low (arm rule).

## Configuration
- TS_ALARM_EN defined:
  - In WRITE, ts_alarm[ch] sets when res ≥ reg_alarm_hi.
  - It clears when res < reg_alarm_hi − reg_alarm_hyst, where the subtraction saturates at 0.
  - Otherwise it holds its value. Reset value is 0.
- TS_ALARM_EN undefined: ts_alarm is tied to 0 and the reg_alarm_* inputs are unused.

## Test plan
- Defaults, mask=4'b1111. ADC model drops DETOK on the START_EN rise and returns it 425 cycles later. DOUT sequence is 10,12,14,16 per channel. Expect ts_out[ch]=13 on all channels, ts_upd pulses in order 0,1,2,3,0, ts_valid=4'hF.
- reg_offset=4'b1000 (-8) with all samples 5 → result 0 (saturates low). reg_offset=+7 with all samples 250 → result 255 (saturates high).
- mask=4'b1010 → only channels 1 and 3 are scanned, alternating. CH_SEL never equals 0 or 2.
- ADC never reasserts DETOK on channel 2 → ts_timeout[2]=1 after 1024 cycles and ts_out[2] is unchanged. On the next good conversion of channel 2, ts_timeout[2] clears.
- Drop FLOCK mid-CONV → on the next edge EN, START_EN and CH_SEL are 0, ts_out is retained. FLOCK back high → restart from PWRUP at channel 0.
- TS_ALARM_EN with hi=100, hyst=5 and results 99,100,97,95,94 → ts_alarm = 0,1,1,1,0.
